booth_seq_ctrl: RTL and testbench

Sequencer and two-channel arbiter for the radix-2 Booth step datapath in the symmetric FIR pipeline. It accepts signed sample × coefficient jobs from two requesters (left/right channel MAC lanes) and grants one job at a time. It iterates one Booth step per clock for 16 clocks, then presents the 41-bit signed product with the granted channel tag on a valid/ready output. The step arithmetic reuses the existing `booth_step` cell; this block owns the registers, counter, FSM and arbitration.

---
 rtl/booth_seq_ctrl.sv | 79 +++++++
 tb/tb_booth_seq_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: two-channel arbiter and 16-step radix-2 Booth multiply sequencer (round-robin with BOOTH_SEQ_RR_EN, else fixed priority)
module booth_seq_ctrl #(
  parameter int NSTEP = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid0,
  input  logic        i_valid1,
  output logic        o_ready0,
  output logic        o_ready1,
  input  logic [23:0] i_mcand0,
  input  logic [23:0] i_mcand1,
  input  logic [15:0] i_mplier0,
  input  logic [15:0] i_mplier1,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [40:0] o_product,
  output logic        o_ch,
  output logic        o_busy
);
  localparam int CW = $clog2(NSTEP);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [24:0] a, m, sum;
  logic [15:0] q;
  logic q0, ch, ptr, grant, accept, last;
  logic [CW-1:0] cnt;
  // Arbitration, Booth add/subtract and next-state selection
  always_comb begin
    grant = (i_valid0 & i_valid1) ? ptr : i_valid1;
    accept = (state == IDLE) & (i_valid0 | i_valid1) & i_rst_n;
    last = cnt == CW'(NSTEP - 1);
    sum = ({q[0], q0} == 2'b10) ? a - m : ({q[0], q0} == 2'b01) ? a + m : a;
    state_nx = state;
    if (state == IDLE) state_nx = accept ? RUN : IDLE;
    else if (state == RUN) state_nx = last ? DONE : RUN;
    else if (state == DONE) state_nx = i_ready ? IDLE : DONE;
  end
  assign o_ready0 = accept & ~grant;
  assign o_ready1 = accept & grant;
  assign o_valid = state == DONE;
  assign o_busy = state != IDLE;
  assign o_product = {a, q};
  assign o_ch = ch;
  // State register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  // Operand capture on acceptance, then one Booth step with arithmetic right shift per clock
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      a <= '0;
      q <= '0;
      q0 <= 1'b0;
      m <= '0;
      cnt <= '0;
      ch <= 1'b0;
    end else if (accept) begin
      a <= '0;
      q <= grant ? i_mplier1 : i_mplier0;
      q0 <= 1'b0;
      m <= grant ? {i_mcand1[23], i_mcand1} : {i_mcand0[23], i_mcand0};
      cnt <= '0;
      ch <= grant;
    end else if (state == RUN) begin
      a <= {sum[24], sum[24:1]};
      q <= {sum[0], q[15:1]};
      q0 <= q[0];
      cnt <= cnt + 1'b1;
    end
`ifdef BOOTH_SEQ_RR_EN
  // Priority pointer flips to the channel that did not just win
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) ptr <= 1'b0;
    else if (accept) ptr <= ~grant;
`else
  assign ptr = 1'b0;
`endif
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb_booth_seq_ctrl: directed table-driven checks of booth_seq_ctrl products, timing, stall, reset and arbitration
module tb_booth_seq_ctrl;
  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic i_valid0 = 1'b0, i_valid1 = 1'b0, i_ready = 1'b0;
  logic [23:0] i_mcand0 = '0, i_mcand1 = '0;
  logic [15:0] i_mplier0 = '0, i_mplier1 = '0;
  logic o_ready0, o_ready1, o_valid, o_ch, o_busy;
  logic [40:0] o_product;
  int n_run = 0, n_fail = 0;
  typedef struct {
    logic ch;
    logic signed [23:0] mc;
    logic signed [15:0] mp;
    logic signed [40:0] p;
  } vec_t;
  vec_t tbl[8];
  booth_seq_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_valid0(i_valid0), .i_valid1(i_valid1),
    .o_ready0(o_ready0), .o_ready1(o_ready1),
    .i_mcand0(i_mcand0), .i_mcand1(i_mcand1),
    .i_mplier0(i_mplier0), .i_mplier1(i_mplier1),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_product(o_product), .o_ch(o_ch), .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string nm, input logic signed [40:0] act, input logic signed [40:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_valid0 = 1'b0;
    i_valid1 = 1'b0;
    i_ready = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask
  // Issue one job, verify 16-cycle latency, product and tag, optionally stall and scramble inputs during RUN
  task automatic run_job(input string nm, input logic ch, input logic signed [23:0] mc,
                         input logic signed [15:0] mp, input logic signed [40:0] p,
                         input int stall, input bit scr);
    int n;
    @(negedge i_clk);
    if (ch) begin i_valid1 = 1'b1; i_mcand1 = mc; i_mplier1 = mp; end
    else begin i_valid0 = 1'b1; i_mcand0 = mc; i_mplier0 = mp; end
    #1 check({nm, " ready"}, {o_ready1, o_ready0}, ch ? 41'd2 : 41'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid0 = 1'b0;
    i_valid1 = 1'b0;
    n = 0;
    while (!o_valid && n < 40) begin
      if (scr) begin
        i_mcand0 = 24'($urandom); i_mcand1 = 24'($urandom);
        i_mplier0 = 16'($urandom); i_mplier1 = 16'($urandom);
      end
      @(posedge i_clk);
      n++;
      @(negedge i_clk);
    end
    check({nm, " latency"}, n, 16);
    check({nm, " product"}, o_product, p);
    check({nm, " ch"}, o_ch, ch);
    for (int i = 0; i < stall; i++) begin
      i_valid0 = 1'b1;
      i_valid1 = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      check($sformatf("%s stall%0d valid", nm, i), o_valid, 1);
      check($sformatf("%s stall%0d product", nm, i), o_product, p);
      check($sformatf("%s stall%0d ch", nm, i), o_ch, ch);
      check($sformatf("%s stall%0d ready", nm, i), {o_ready1, o_ready0}, 0);
    end
    i_valid0 = 1'b0;
    i_valid1 = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ready = 1'b0;
    check({nm, " post valid"}, o_valid, 0);
    check({nm, " post busy"}, o_busy, 0);
  endtask
  initial begin
    int n;
    logic [3:0] g;
    tbl[0] = '{1'b0, 24'sd1000, 16'sd3, 41'sd3000};
    tbl[1] = '{1'b1, -24'sd1, -16'sd1, 41'sd1};
    tbl[2] = '{1'b0, 24'sd8388607, -16'sd32768, -41'sd274877874176};
    tbl[3] = '{1'b1, -24'sd8388608, -16'sd32768, 41'sd274877906944};
    tbl[4] = '{1'b0, -24'sd5, 16'sd7, -41'sd35};
    tbl[5] = '{1'b1, 24'sd0, 16'sd12345, 41'sd0};
    tbl[6] = '{1'b0, 24'sd123, -16'sd1, -41'sd123};
    tbl[7] = '{1'b1, 24'sd8388607, 16'sd32767, 41'sd274869485569};
    #2;
    i_valid0 = 1'b1;
    #1 check("rst ready", {o_ready1, o_ready0}, 0);
    check("rst valid", o_valid, 0);
    check("rst product", o_product, 0);
    check("rst ch", o_ch, 0);
    check("rst busy", o_busy, 0);
    i_valid0 = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 8; i++)
      run_job($sformatf("vec%0d", i), tbl[i].ch, tbl[i].mc, tbl[i].mp, tbl[i].p, 0, 1'b0);
    run_job("stall", 1'b1, -24'sd77, 16'sd300, -41'sd23100, 10, 1'b0);
    run_job("scramble", 1'b0, 24'sd4660, -16'sd4661, -41'sd21720260, 0, 1'b1);
    @(negedge i_clk);
    i_valid1 = 1'b1;
    i_mcand1 = 24'd999;
    i_mplier1 = 16'd999;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid1 = 1'b0;
    repeat (8) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_valid0 = 1'b1;
    #1 check("abort ready", {o_ready1, o_ready0}, 0);
    check("abort valid", o_valid, 0);
    check("abort product", o_product, 0);
    check("abort ch", o_ch, 0);
    check("abort busy", o_busy, 0);
    i_valid0 = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_job("after abort", 1'b0, 24'sd11, 16'sd13, 41'sd143, 0, 1'b0);
    do_reset();
    i_valid0 = 1'b1;
    i_valid1 = 1'b1;
    i_ready = 1'b1;
    g = '0;
    for (int j = 0; j < 4; j++) begin
      n = 0;
      while (!(o_ready0 | o_ready1) && n < 40) begin
        @(posedge i_clk);
        n++;
        @(negedge i_clk);
      end
      check($sformatf("arb%0d wait", j), n < 40, 1);
      check($sformatf("arb%0d exclusive", j), o_ready0 & o_ready1, 0);
      g[j] = o_ready1;
      @(posedge i_clk);
      @(negedge i_clk);
    end
`ifdef BOOTH_SEQ_RR_EN
    check("arb order", g, 41'b1010);
`else
    check("arb order", g, 41'b0000);
`endif
    i_valid0 = 1'b0;
    i_valid1 = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
